// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller in front of a
// word-addressed RAM with a change-triggered busy interface.
module dm_cache_ctrl #(
  parameter int unsigned INDEX_SIZE   = 6,
  parameter int unsigned MEM_AW       = 12,
  parameter int unsigned MEM_MIN_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_hit,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_mode,
  input  logic        mem_response,
  input  logic [31:0] mem_out,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int unsigned LINES = 2 ** INDEX_SIZE;
  localparam int unsigned TAG_W = MEM_AW - INDEX_SIZE;
  localparam int unsigned CNT_W = (MEM_MIN_WAIT > 1) ? $clog2(MEM_MIN_WAIT) : 1;
  // Issue edge counts as the first of MEM_MIN_WAIT cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_MIN_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MEM_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [MEM_AW-1:0]       addr_q, addr_d;
  logic                    we_q, we_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    hit_q, hit_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q [LINES];
  logic [31:0]             data_q [LINES];
  logic                    done_q, done_d;
  logic                    hit_out_q, hit_out_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [MEM_AW-1:0]       mem_addr_q, mem_addr_d;
  logic [31:0]             mem_data_q, mem_data_d;
  logic                    mem_mode_q, mem_mode_d;
  logic [15:0]             hit_cnt_q, hit_cnt_d;
  logic [15:0]             miss_cnt_q, miss_cnt_d;

  logic                    line_we;
  logic [31:0]             line_data;
  logic [INDEX_SIZE-1:0]   idx;
  logic [TAG_W-1:0]        tg;
  logic                    lookup_hit;
  logic                    unused_addr_hi;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign idx            = addr_q[INDEX_SIZE-1:0];
  assign tg             = addr_q[MEM_AW-1:INDEX_SIZE];
  assign lookup_hit     = valid_q[idx] && (tag_q[idx] == tg);
  assign unused_addr_hi = ^cpu_addr[31:MEM_AW];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    hit_d      = hit_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    hit_out_d  = hit_out_q;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_mode_d = mem_mode_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    line_we    = 1'b0;
    line_data  = mem_out;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr[MEM_AW-1:0];
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d = lookup_hit;
        if (!we_q && lookup_hit) begin
          rdata_d   = data_q[idx];
          hit_out_d = 1'b1;
          done_d    = 1'b1;
          hit_cnt_d = sat_inc(hit_cnt_q);
          state_d   = S_IDLE;
        end else begin
          // Reads leave mem_data alone so only address/mode can trigger the RAM.
          mem_addr_d = addr_q;
          mem_mode_d = we_q;
          if (we_q) mem_data_d = wdata_q;
          cnt_d   = CNT_LOAD;
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!mem_response) begin
          done_d    = 1'b1;
          hit_out_d = hit_q;
          state_d   = S_IDLE;
          if (!we_q) begin
            line_we      = 1'b1;
            valid_d[idx] = 1'b1;
            rdata_d      = mem_out;
            miss_cnt_d   = sat_inc(miss_cnt_q);
          end else if (hit_q) begin
            line_we   = 1'b1;
            line_data = wdata_q;
            hit_cnt_d = sat_inc(hit_cnt_q);
          end else begin
            miss_cnt_d = sat_inc(miss_cnt_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      hit_q      <= 1'b0;
      cnt_q      <= '0;
      valid_q    <= '0;
      done_q     <= 1'b0;
      hit_out_q  <= 1'b0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_mode_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      hit_q      <= hit_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      hit_out_q  <= hit_out_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_mode_q <= mem_mode_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[idx]  <= tg;
      data_q[idx] <= line_data;
    end
  end

  assign cpu_ready   = (state_q == S_IDLE);
  assign cpu_done    = done_q;
  assign cpu_rdata   = rdata_q;
  assign cpu_hit     = hit_out_q;
  assign mem_address = 32'(mem_addr_q);
  assign mem_data    = mem_data_q;
  assign mem_mode    = mem_mode_q;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

endmodule

// File: doc/dm_cache_ctrl.md
# dm_cache_ctrl

Direct-mapped, write-through, no-write-allocate cache controller that sits directly upstream of the word-addressed RAM. It accepts one CPU request at a time and serves read hits from its own line arrays. It forwards read misses and all writes to the RAM over the RAM's change-triggered busy interface. It owns all coherence: it updates its own line on a write hit, so the RAM needs no knowledge of the cache.

## Interface
- `INDEX_SIZE`, 6: index bits; `LINES = 2**INDEX_SIZE`.
- `MEM_AW`, 12: effective RAM address bits (RAM depth 4096). Tag width is `MEM_AW-INDEX_SIZE`.
- `MEM_MIN_WAIT`, 3: minimum cycles from driving a memory request to sampling completion.
- `clk` in 1: single clock, all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: request valid; sampled only when `cpu_ready`=1.
- `cpu_we` in 1: 1 write, 0 read.
- `cpu_addr` in 32: word address; bits above `MEM_AW-1` ignored (modulo 4096).
- `cpu_wdata` in 32: write data.
- `cpu_ready` out 1: 1 when IDLE.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: read result, valid while `cpu_done`=1 and held until the next completion.
- `cpu_hit` out 1: lookup result of the completing request, qualified by `cpu_done`.
- `mem_address` out 32: to RAM `address`, zero-extended `MEM_AW` bits.
- `mem_data` out 32: to RAM `data`.
- `mem_mode` out 1: to RAM `mode` (1 write).
- `mem_response` in 1: RAM busy (1 busy).
- `mem_out` in 32: RAM read data.
- `hit_count`, `miss_count` out 16 each: saturating statistics counters.

## Operation
- Arrays: `valid[LINES]` (flops, async-cleared), `tag[LINES]`, `data[LINES]` (no reset). Index = `addr[INDEX_SIZE-1:0]`; tag = `addr[MEM_AW-1:INDEX_SIZE]`.
- States:
  - IDLE: when `cpu_req`=1, capture addr, we, wdata → LOOKUP.
  - LOOKUP: hit = valid & tag match.
    - Read hit: `cpu_rdata`=line data, `cpu_hit`=1, `cpu_done`=1, hit_count+1 → IDLE.
    - Read miss or any write: drive mem_* → MEM_WAIT. Load the wait counter.
  - MEM_WAIT: complete on the first edge where the counter has expired and `mem_response`=0.
    - Read completion: fill the line (valid=1, tag, data=`mem_out`), `cpu_rdata`=`mem_out`, miss_count+1.
    - Write completion: if hit, line data=wdata; hit or miss count accordingly. On a miss the line is untouched.
    - Every completion pulses `cpu_done` → IDLE.
- mem_* hold their last value between transactions and never return to zero. The RAM fires on any change of address, data or mode, so releasing the signals would cause spurious RAM operations.
- An identical back-to-back memory request produces no RAM busy pulse. The minimum wait still completes it correctly (the read value is unchanged, the write is already applied).
- Counters saturate at 0xFFFF.

## Timing
- Reset values:
  - `valid`=0 for all lines.
  - State = IDLE, so `cpu_ready`=1.
  - `cpu_done`, `cpu_hit`, `cpu_rdata`, mem_*, counters = 0.
  - mem_*=0 matches the RAM's power-up previous-value registers, so reset causes no RAM operation.
- Accept edge A: read hit gives `cpu_done` high in the cycle after edge A+1.
- Memory path: issue at edge A+1; earliest completion at edge A+1+`MEM_MIN_WAIT` (A+4 with the default), with `mem_response` sampled 0 there.
- `MEM_MIN_WAIT`=3 covers the RAM's sequence: see change, raise busy, perform operation, drop busy.
- `cpu_ready` and `cpu_done` are both high in the completion cycle, so back-to-back requests are accepted one cycle after done.
- `cpu_req` while not ready is ignored; there is no queueing.
- Reset mid-transaction aborts immediately with no `cpu_done`, and all lines are invalidated. A write the RAM already latched may still land in RAM; that is acceptable, since the cache is empty.

## Test plan
- Reset, then read 0x005 (RAM holds 0xA5A5) → miss, `cpu_done` at A+4, rdata 0xA5A5, miss_count=1. Repeat the read → hit, done at A+1, hit_count=1.
- Write 0x005 ← 0x1234 after the line is cached → RAM[5]=0x1234 and line updated. Following read hits with 0x1234.
- Write 0x0C7 ← 0xBEEF to an uncached line → RAM updated, line stays invalid. Following read misses and returns 0xBEEF.
- Conflict:
  - Read 0x045 then 0x005 (same index 5, tags 1 and 0) → both miss, line now holds tag 0.
  - Read 0x045 again → miss.
  - Address 0x1045 aliases to 0x045.
- Identical repeat write of 0x005 ← 0x1234 with no intervening memory op → completes at A+4 with no deadlock.
- Assert `rst_n` during MEM_WAIT → no `cpu_done`, `cpu_ready`=1 after release, and the previously cached address misses.
